lds_unit: RTL and testbench
===========================

// Module: lds_unit
// PURPOSE
//  Load/store sequencer feeding the reg_file write port for kLDS instructions.
//  - Takes the address from r0 (data_outB) and the store data from rs (data_outA).
//  - Runs a req/ack handshake with data memory.
//  - For loads, returns the read byte as a one-cycle rf_we/rf_wdata write-back to rs.
//  - Holds busy so the fetch stage stalls the PC while an access is in flight.
// PARAMETERS
//  W        8    data path / address width
//  TIMEOUT  15   max cycles mem_req may wait for mem_ack before abort (1..255)
// PORTS
//  CLK        in   1  system clock, all state on rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  start      in   1  decode strobe: kLDS issued this cycle (sampled only in IDLE)
//  is_store   in   1  1=store rs to mem[r0], 0=load mem[r0] into rs
//  addr       in   W  memory address (reg_file data_outB, r0)
//  st_data    in   W  store data (reg_file data_outA, rs)
//  mem_req    out  1  memory request, held until mem_ack or timeout
//  mem_we     out  1  write qualifier, valid while mem_req=1
//  mem_addr   out  W  latched address, valid while mem_req=1
//  mem_wdata  out  W  latched store data, valid while mem_req=1
//  mem_rdata  in   W  read data, valid in the mem_ack cycle
//  mem_ack    in   1  memory completion, one cycle
//  rf_we      out  1  reg_file write enable pulse (load completion only)
//  rf_wdata   out  W  reg_file data_in for load write-back
//  busy       out  1  1 in any state but IDLE; fetch stalls on busy|start
//  done       out  1  one-cycle pulse when an access retires (load or store)
//  err        out  1  sticky timeout flag, cleared by the next accepted start
// BEHAVIOUR
//  Reset: all outputs and internal registers are 0 and the state is IDLE.
//   - Reset is async: mem_req drops immediately; any access in flight is abandoned.
//  States: IDLE, REQ, WB.
//   IDLE: when start=1, latch addr, st_data and is_store; clear err; go to REQ.
//   REQ: mem_req=1, mem_we=latched is_store, cycle counter increments each cycle.
//    - mem_ack=1 on a load: capture mem_rdata into the rdata register; go to WB.
//    - mem_ack=1 on a store: pulse done in the next cycle; go to IDLE.
//    - No ack and counter==TIMEOUT-1: set err=1, pulse done, go to IDLE.
//      No rf_we is issued in this case.
//   WB: rf_we=1 and done=1 for exactly one cycle, rf_wdata=rdata; go to IDLE.
//  Outputs are registered; there are no combinational paths from inputs to outputs.
//  Latency, with start sampled at edge 0:
//   - mem_req rises after edge 0 (counts as cycle 1).
//   - If ack arrives in REQ cycle k, rf_we/done are high in cycle k+1.
//   - Minimum load: start -> rf_we = 2 cycles. Minimum store: start -> done = 2 cycles.
//  rf_wdata holds its last loaded value when rf_we=0. It changes only on load ack.
//  mem_addr, mem_wdata and mem_we are stable for the whole REQ interval.
//  They hold their last value after the access.
//  Boundary conditions:
//   - start while busy=1: ignored, not queued. Decode must not issue then.
//   - mem_ack in IDLE or WB: ignored.
//   - mem_ack in the same cycle the counter reaches TIMEOUT-1: ack wins, err stays 0.
//   - Counter is $clog2(TIMEOUT+1) bits and resets to 0 on each entry to REQ.
//     It never wraps.
//   - start=1 in the same cycle reset_n deasserts: ignored. The first start is
//     sampled on the following edge.
//   - Back-to-back: start may be accepted in the cycle after done (IDLE).
// TESTING
//  1 reset_n=0 mid-REQ (mem_req=1) -> mem_req, busy, rf_we, err = 0 immediately;
//    IDLE after release.
//  2 load addr=8'h3C, ack 1 cycle after req, mem_rdata=8'hA5 -> mem_we=0,
//    mem_addr=8'h3C; rf_we=1 with rf_wdata=8'hA5 2 cycles after start, done=1 same cycle.
//  3 store addr=8'h10, st_data=8'h7E, ack delayed 4 cycles -> mem_we=1,
//    mem_wdata=8'h7E stable all 4 cycles; done 1 cycle after ack; rf_we never set.
//  4 load with no ack, TIMEOUT=15 -> mem_req high 15 cycles, then err=1 and done=1,
//    rf_we=0; next start clears err.
//  5 start pulsed again while busy (addr=8'hFF) -> ignored; mem_addr keeps the first
//    address; exactly one done.
//  6 ack on the final timeout cycle with mem_rdata=8'h01 -> err=0; rf_we with 8'h01.

Source files
------------

// File: rtl/lds_unit.sv
// Load/store sequencer for kLDS: drives the data-memory req/ack handshake
// and returns load data to the reg_file write port.
module lds_unit #(
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         CLK,
    input  logic         reset_n,
    input  logic         start,
    input  logic         is_store,
    input  logic [W-1:0] addr,
    input  logic [W-1:0] st_data,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         rf_we,
    output logic [W-1:0] rf_wdata,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          armed_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [W-1:0]  addr_q, addr_d;
    logic [W-1:0]  wdata_q, wdata_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          rf_we_q, rf_we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          accept;
    logic          tmo;

    // armed_q blocks a start seen on the first edge after reset release
    assign accept = start & armed_q;
    assign tmo    = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rf_we_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    we_d    = is_store;
                    addr_d  = addr;
                    wdata_d = st_data;
                    err_d   = 1'b0;
                end
            end
            REQ: begin
                // ack takes priority over a coincident timeout
                if (mem_ack && !we_q) begin
                    state_d = WB;
                    rdata_d = mem_rdata;
                    rf_we_d = 1'b1;
                    done_d  = 1'b1;
                end else if (mem_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmo) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            rf_we_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            rf_we_q <= rf_we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rf_we     = rf_we_q;
    assign rf_wdata  = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lds_unit.sv
// Bench for lds_unit: directed scenarios then random accesses against a
// cycle-count reference model and a reference memory.
module tb_lds_unit;

    localparam int TMO = 15;

    logic       CLK;
    logic       reset_n;
    logic       start;
    logic       is_store;
    logic [7:0] addr;
    logic [7:0] st_data;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       rf_we;
    logic [7:0] rf_wdata;
    logic       busy;
    logic       done;
    logic       err;

    int vectors;
    int miscompares;

    logic [7:0] ref_mem [256];
    logic [7:0] dev_mem [256];
    logic [7:0] last_load;
    logic       err_exp;

    lds_unit #(.W(8), .TIMEOUT(TMO)) dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .start     (start),
        .is_store  (is_store),
        .addr      (addr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; leaves the DUT idle, armed, #1 after an edge.
    task automatic pulse_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        last_load = 8'h00;
        err_exp   = 1'b0;
        mem_ack   = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        start    = 1'b1;
        is_store = 1'b0;
        addr     = 8'($urandom);
        reset_n  = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        chk("rst_start_ignored", busy, 0);
        @(posedge CLK);
        #1;
    endtask

    // ackc: REQ cycle carrying mem_ack (1..TMO), anything else = no ack.
    task automatic access(input bit st, input logic [7:0] a,
                          input logic [7:0] d, input int ackc,
                          input bit repulse);
        bit         acked;
        bit         wb;
        int         kend;
        logic [7:0] exp_rf;
        acked = (ackc >= 1 && ackc <= TMO);
        kend  = acked ? ackc : TMO;
        wb    = acked && !st;
        start     = 1'b1;
        is_store  = st;
        addr      = a;
        st_data   = d;
        mem_ack   = 1'($urandom);
        mem_rdata = 8'($urandom);
        @(negedge CLK);
        chk("idle_busy", busy, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_done", done, 0);
        chk("idle_rf_we", rf_we, 0);
        chk("idle_err", err, err_exp);
        @(posedge CLK);
        #1;
        for (int c = 1; c <= kend; c++) begin
            start = repulse ? (c == 2) : ($urandom_range(0, 3) == 0);
            is_store = 1'($urandom);
            addr     = (repulse && c == 2) ? 8'hFF : 8'($urandom);
            st_data  = 8'($urandom);
            mem_ack   = (c == ackc);
            mem_rdata = 8'($urandom);
            if (mem_ack) begin
                if (mem_we) dev_mem[mem_addr] = mem_wdata;
                else mem_rdata = dev_mem[mem_addr];
            end
            @(negedge CLK);
            chk("req_req", mem_req, 1);
            chk("req_busy", busy, 1);
            chk("req_we", mem_we, st);
            chk("req_addr", mem_addr, a);
            chk("req_wdata", mem_wdata, d);
            chk("req_rf_we", rf_we, 0);
            chk("req_done", done, 0);
            chk("req_err", err, 0);
            chk("req_rf_wdata", rf_wdata, last_load);
            @(posedge CLK);
            #1;
        end
        start     = 1'b0;
        mem_ack   = 1'($urandom);
        mem_rdata = 8'($urandom);
        @(negedge CLK);
        exp_rf = wb ? ref_mem[a] : last_load;
        chk("end_req", mem_req, 0);
        chk("end_done", done, 1);
        chk("end_rf_we", rf_we, wb);
        chk("end_err", err, !acked);
        chk("end_busy", busy, wb);
        chk("end_rf_wdata", rf_wdata, exp_rf);
        chk("end_addr_hold", mem_addr, a);
        last_load = exp_rf;
        err_exp   = !acked;
        if (st && acked) ref_mem[a] = d;
        @(posedge CLK);
        #1 mem_ack = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b1;
        start       = 1'b0;
        is_store    = 1'b0;
        addr        = 8'h00;
        st_data     = 8'h00;
        mem_rdata   = 8'h00;
        mem_ack     = 1'b0;
        last_load   = 8'h00;
        err_exp     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            dev_mem[i] = ref_mem[i];
        end
        ref_mem[8'h3C] = 8'hA5;
        dev_mem[8'h3C] = 8'hA5;
        ref_mem[8'h22] = 8'h01;
        dev_mem[8'h22] = 8'h01;
        @(posedge CLK);
        #1;
        pulse_reset();

        access(1'b0, 8'h3C, 8'h00, 1, 1'b0);
        access(1'b1, 8'h10, 8'h7E, 4, 1'b0);
        access(1'b0, 8'h40, 8'h00, 0, 1'b0);
        access(1'b0, 8'h3C, 8'h33, 4, 1'b1);
        access(1'b0, 8'h22, 8'h00, TMO, 1'b0);
        access(1'b0, 8'h10, 8'h00, 2, 1'b0);
        access(1'b1, 8'h50, 8'h99, TMO + 1, 1'b0);
        pulse_reset();

        start    = 1'b1;
        is_store = 1'b0;
        addr     = 8'h55;
        @(posedge CLK);
        #1 start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("pre_rst_req", mem_req, 1);
            @(posedge CLK);
            #1;
        end
        pulse_reset();

        for (int n = 0; n < 40; n++) begin
            int         ackc;
            logic [7:0] a;
            a    = 8'($urandom_range(0, 7));
            ackc = ($urandom_range(0, 9) < 2) ?
                   int'($urandom_range(TMO - 1, TMO + 2)) :
                   int'($urandom_range(1, 5));
            access(1'($urandom), a, 8'($urandom), ackc,
                   ($urandom_range(0, 7) == 0) && ackc >= 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
